mf_ceg_multi: RTL and testbench

- Multi-channel fractional clock-enable generator, built as the parametrised successor to the fixed five-output PLL wrapper.
- Runs on the single PLL master clock and produces NUM_CH single-cycle clock-enable pulses. Each channel is a phase-accumulator NCO with its own programmable increment (frequency) and start phase.
- Lets cores derive 20 / 6.67 / 3.33 MHz-class enables, and phase-shifted copies of them, without extra PLL outputs.
- Sits directly after the PLL wrapper. Its lock indication is ANDed with the PLL locked output by the integrating top.

---
 rtl/mf_ceg_pkg.sv | 31 +++
 rtl/mf_ceg_nco.sv | 45 ++++
 rtl/mf_ceg_multi.sv | 109 ++++++++++
 tb/tb_mf_ceg_multi.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mf_ceg_pkg.sv
// Shared constants, the cycle-action encoding and helper functions for the
// multi-channel fractional clock-enable generator.
package mf_ceg_pkg;

  localparam int DEF_ACC_W       = 16;
  localparam int DEF_LOCK_CYCLES = 8;
  localparam int LOCK_CNT_W      = 8;

  // What the generator does at a given refclk edge.
  typedef enum logic [1:0] {
    CYC_RUN    = 2'd0,
    CYC_PAUSE  = 2'd1,
    CYC_COMMIT = 2'd2
  } cyc_action_e;

  // Width of the channel-select field; never narrower than one bit.
  function automatic int ch_idx_w(input int num_ch);
    if (num_ch <= 1) return 1;
    return $clog2(num_ch);
  endfunction

  // Increment giving f_out from f_ref with an acc_w-bit accumulator, rounded
  // to nearest. Intended for elaboration-time constants only.
  function automatic logic [31:0] calc_inc(input real f_out, input real f_ref,
                                           input int acc_w);
    real scaled;
    scaled = f_out * (2.0 ** acc_w) / f_ref;
    return 32'($rtoi(scaled + 0.5));
  endfunction

endpackage

// File: rtl/mf_ceg_nco.sv
// One phase-accumulator channel: the carry out of acc + inc becomes a
// single-cycle enable pulse.
module mf_ceg_nco
  import mf_ceg_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [ACC_W-1:0] load_phase,
  input  logic [ACC_W-1:0] load_inc,
  input  logic             run,
  output logic             ce
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;

  // Next accumulator value with the wrap carry kept in the top bit.
  always_comb begin
    sum = {1'b0, acc} + {1'b0, inc};
  end

  // Load realigns to the start phase; run advances; anything else holds acc
  // and keeps the enable low.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      inc <= '0;
      ce  <= 1'b0;
    end else if (load) begin
      acc <= load_phase;
      inc <= load_inc;
      ce  <= 1'b0;
    end else if (run) begin
      acc <= sum[ACC_W-1:0];
      ce  <= sum[ACC_W];
    end else begin
      ce  <= 1'b0;
    end
  end

endmodule

// File: rtl/mf_ceg_multi.sv
// Multi-channel fractional clock-enable generator. Owns the per-channel shadow
// configuration, the commit/pause decode and the lock counter; each channel's
// accumulator lives in an mf_ceg_nco instance.
module mf_ceg_multi
  import mf_ceg_pkg::*;
#(
  parameter int NUM_CH      = 5,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                        refclk,
  input  logic                        rst_n,
  input  logic                        cfg_wr,
  input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]            cfg_inc,
  input  logic [ACC_W-1:0]            cfg_phase,
  input  logic                        cfg_commit,
  input  logic                        pause,
  output logic [NUM_CH-1:0]           ce,
  output logic                        locked
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  logic [ACC_W-1:0]      shadow_inc   [NUM_CH];
  logic [ACC_W-1:0]      shadow_phase [NUM_CH];
  logic [ACC_W-1:0]      eff_inc      [NUM_CH];
  logic [ACC_W-1:0]      eff_phase    [NUM_CH];
  logic [NUM_CH-1:0]     wr_hit;
  logic [LOCK_CNT_W-1:0] lock_cnt;
  cyc_action_e           action;
  logic                  do_load;
  logic                  do_run;

  // Commit overrides pause; pause only matters on edges without a commit.
  always_comb begin
    action = CYC_RUN;
    if (cfg_commit)
      action = CYC_COMMIT;
    else if (pause)
      action = CYC_PAUSE;
  end

  assign do_load = (action == CYC_COMMIT);
  assign do_run  = (action == CYC_RUN);

  // A write to a channel index beyond NUM_CH matches no channel and is lost.
  // A write in the commit cycle is forwarded so the commit sees the new value.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_hit[g]    = cfg_wr && (cfg_ch == CH_W'(g));
    assign eff_inc[g]   = wr_hit[g] ? cfg_inc   : shadow_inc[g];
    assign eff_phase[g] = wr_hit[g] ? cfg_phase : shadow_phase[g];

    mf_ceg_nco #(
      .ACC_W (ACC_W)
    ) u_nco (
      .refclk     (refclk),
      .rst_n      (rst_n),
      .load       (do_load),
      .load_phase (eff_phase[g]),
      .load_inc   (eff_inc[g]),
      .run        (do_run),
      .ce         (ce[g])
    );
  end

  // Shadow registers only change on a matching configuration write.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_inc[i]   <= '0;
        shadow_phase[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_hit[i]) begin
          shadow_inc[i]   <= cfg_inc;
          shadow_phase[i] <= cfg_phase;
        end
      end
    end
  end

  // Lock counter restarts on every commit, counts down on run edges only, and
  // raises locked on its final step; pause freezes both counter and flag.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      case (action)
        CYC_COMMIT: begin
          lock_cnt <= LOCK_CNT_W'(LOCK_CYCLES);
          locked   <= 1'b0;
        end
        CYC_RUN: begin
          if (lock_cnt != '0) begin
            lock_cnt <= lock_cnt - LOCK_CNT_W'(1);
            if (lock_cnt == LOCK_CNT_W'(1))
              locked <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mf_ceg_multi.sv
// Self-checking bench for mf_ceg_multi: directed scenarios plus a random
// phase, compared every cycle against an arithmetic model of the NCO rules.
module tb_mf_ceg_multi;
  import mf_ceg_pkg::*;

  localparam int NUM_CH      = 5;
  localparam int ACC_W       = 16;
  localparam int LOCK_CYCLES = 8;
  localparam int CH_W        = 3;

  logic              refclk;
  logic              rst_n;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic [ACC_W-1:0]  cfg_phase;
  logic              cfg_commit;
  logic              pause;
  logic [NUM_CH-1:0] ce;
  logic              locked;

  // Reference model: a channel's pulse count after n run edges is
  // floor((phase + n*inc) / 2^ACC_W); a pulse occurs when that count steps.
  longint            m_sh_inc  [NUM_CH];
  longint            m_sh_ph   [NUM_CH];
  longint            m_act_inc [NUM_CH];
  longint            m_act_ph  [NUM_CH];
  longint            run_n;
  bit                committed;
  logic [NUM_CH-1:0] exp_ce;
  logic              exp_locked;

  int tests;
  int fails;
  int step_idx;
  int first_idx;
  int pulse_cnt;
  int zero_cnt;
  logic [11:0] vec0, vec1, vecl;
  logic [5:0]  vec_fast;
  logic [15:0] inc0;

  mf_ceg_multi #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .cfg_wr     (cfg_wr),
    .cfg_ch     (cfg_ch),
    .cfg_inc    (cfg_inc),
    .cfg_phase  (cfg_phase),
    .cfg_commit (cfg_commit),
    .pause      (pause),
    .ce         (ce),
    .locked     (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  function automatic logic pulse_at(input longint ph, input longint inc,
                                    input longint n);
    return ((ph + n * inc) >> ACC_W) != ((ph + (n - 1) * inc) >> ACC_W);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_sh_inc[i] = 0; m_sh_ph[i] = 0; m_act_inc[i] = 0; m_act_ph[i] = 0;
    end
    run_n = 0;
    committed = 0;
    exp_ce = '0;
    exp_locked = 1'b0;
  endtask

  task automatic model_edge(input logic wr, input logic [CH_W-1:0] ch,
                            input logic [15:0] inc, input logic [15:0] ph,
                            input logic commit, input logic ps);
    if (wr && (int'(ch) < NUM_CH)) begin
      m_sh_inc[ch] = longint'(inc);
      m_sh_ph[ch]  = longint'(ph);
    end
    if (commit) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_act_inc[i] = m_sh_inc[i];
        m_act_ph[i]  = m_sh_ph[i];
      end
      run_n = 0;
      committed = 1;
      exp_ce = '0;
    end else if (ps) begin
      exp_ce = '0;
    end else begin
      run_n++;
      for (int i = 0; i < NUM_CH; i++)
        exp_ce[i] = pulse_at(m_act_ph[i], m_act_inc[i], run_n);
    end
    exp_locked = committed && (run_n >= LOCK_CYCLES);
  endtask

  task automatic checkOutput(input string tag);
    tests++;
    assert (ce === exp_ce) else begin
      fails++;
      $error("[TB] FAIL %s ce: got %b expected %b", tag, ce, exp_ce);
    end
    tests++;
    assert (locked === exp_locked) else begin
      fails++;
      $error("[TB] FAIL %s locked: got %b expected %b", tag, locked, exp_locked);
    end
  endtask

  task automatic checkValue(input string tag, input longint observed,
                            input longint expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One refclk edge with the given inputs; outputs are checked 1 ns later.
  task automatic applyStimulus(input logic wr, input logic [CH_W-1:0] ch,
                               input logic [15:0] inc, input logic [15:0] ph,
                               input logic commit, input logic ps,
                               input string tag);
    cfg_wr = wr; cfg_ch = ch; cfg_inc = inc; cfg_phase = ph;
    cfg_commit = commit; pause = ps;
    @(posedge refclk);
    model_edge(wr, ch, inc, ph, commit, ps);
    #1;
    cfg_wr = 1'b0; cfg_commit = 1'b0; pause = 1'b0;
    checkOutput(tag);
  endtask

  task automatic runIdle(input int n, input string tag);
    for (int k = 0; k < n; k++)
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    tests = 0; fails = 0;
    inc0 = 16'(calc_inc(20.0e6, 80.0e6, ACC_W));
    rst_n = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_phase = '0;
    cfg_commit = 1'b0; pause = 1'b0;
    model_reset();

    // Reset state, then no commit yet: nothing pulses, never locked.
    repeat (2) @(posedge refclk);
    #1;
    checkOutput("reset_hold");
    rst_n = 1'b1;
    runIdle(12, "no_commit");

    // Configure: ch0 20 MHz-class, ch1 phase-shifted, ch2 0x3000, ch3 off,
    // ch4 near-full rate; out-of-range channel write is ignored.
    applyStimulus(1'b1, 3'd0, inc0, 16'h0000, 1'b0, 1'b0, "cfg0");
    applyStimulus(1'b1, 3'd1, 16'h4000, 16'hC000, 1'b0, 1'b0, "cfg1");
    applyStimulus(1'b1, 3'd2, 16'h3000, 16'h0123, 1'b0, 1'b0, "cfg2");
    applyStimulus(1'b1, 3'd3, 16'h0000, 16'h5555, 1'b0, 1'b0, "cfg3");
    applyStimulus(1'b1, 3'd4, 16'hFFFF, 16'h0000, 1'b0, 1'b0, "cfg4");
    applyStimulus(1'b1, 3'd7, 16'h8000, 16'h8000, 1'b0, 1'b0, "cfg_bad_ch");
    runIdle(3, "pre_commit");

    // Basic rate, latency, phase offset and lock timing.
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, "commit1");
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, "run1");
      vec0[e-1] = ce[0]; vec1[e-1] = ce[1]; vecl[e-1] = locked;
    end
    checkValue("ch0_pulse_edges", longint'(vec0), longint'(12'h888));
    checkValue("ch1_pulse_edges", longint'(vec1), longint'(12'h111));
    checkValue("lock_edges", longint'(vecl), longint'(12'hF80));

    // Pause 10 cycles after E3: next ch0 pulse moves from E4 to E14.
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, "commit_p");
    runIdle(3, "pre_pause");
    for (int k = 0; k < 10; k++)
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, "pause");
    first_idx = 0;
    for (int e = 14; e <= 20; e++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, "post_pause");
      if (ce[0] && first_idx == 0) first_idx = e;
    end
    checkValue("pause_delay", first_idx, 14);

    // Commit and pause together, then a restart commit at E5.
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1, "commit_pause");
    runIdle(4, "restart_pre");
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, "commit_restart");
    first_idx = 0;
    for (int e = 6; e <= 16; e++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, "restart_run");
      if (locked && first_idx == 0) first_idx = e;
    end
    checkValue("restart_lock_edge", first_idx, 13);

    // Shadow isolation, then same-cycle write with commit.
    applyStimulus(1'b1, 3'd0, 16'h8000, 16'h0000, 1'b0, 1'b0, "shadow_wr");
    runIdle(8, "shadow_iso");
    applyStimulus(1'b1, 3'd0, 16'h8000, 16'h0000, 1'b1, 1'b0, "wr_commit");
    for (int e = 1; e <= 6; e++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, "fast_run");
      vec_fast[e-1] = ce[0];
    end
    checkValue("ch0_fast_edges", longint'(vec_fast), longint'(6'b101010));

    // A locked system stays locked across a pause.
    runIdle(4, "to_lock");
    for (int k = 0; k < 10; k++)
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, "pause_locked");
    checkValue("locked_thru_pause", longint'(locked), 1);

    // Exact rate over a full accumulator period.
    applyStimulus(1'b1, 3'd2, 16'h3000, 16'($urandom), 1'b1, 1'b0, "commit_rate");
    pulse_cnt = 0; zero_cnt = 0;
    for (int k = 0; k < 65536; k++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, "rate_run");
      if (ce[2]) pulse_cnt++;
      if (ce[3]) zero_cnt++;
    end
    checkValue("ch2_pulse_count", pulse_cnt, (longint'(16'h3000) * 65536) >> ACC_W);
    checkValue("ch3_pulse_count", zero_cnt, 0);

    // Random configuration, commit and pause traffic.
    for (int k = 0; k < 400; k++)
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    16'($urandom), 16'($urandom),
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 4) == 0),
                    "random");

    // Asynchronous reset while pulsing and locked.
    applyStimulus(1'b1, 3'd4, 16'hFFFF, 16'h0000, 1'b1, 1'b0, "commit_full");
    runIdle(10, "pre_reset");
    checkValue("locked_before_reset", longint'(locked), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checkOutput("async_reset");
    #1;
    rst_n = 1'b1;
    runIdle(10, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
